// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its coefficient loader.
//   COEF_W          : coefficient width in bits
//   coef_t          : signed coefficient type
//   coef_ld_state_t : loader FSM state encoding
package fir_pkg;

    localparam int COEF_W = 16;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } coef_ld_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register bank: TAPS words with an indexed write port and a bulk
// copy port. The bulk copy wins over the indexed write. Async active-low clear.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears all words)
//   wr_en/wr_idx/wr_data single-word write
//   copy_en/copy_data   load every word at once
//   q                   current bank contents
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAPS  = 401,
    parameter int W     = COEF_W,
    parameter int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_data,
    input  logic             copy_en,
    input  logic [W-1:0]     copy_data [TAPS],
    output logic [W-1:0]     q         [TAPS]
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                q[i] <= '0;
            end
        end else if (copy_en) begin
            for (int i = 0; i < TAPS; i++) begin
                q[i] <= copy_data[i];
            end
        end else if (wr_en) begin
            q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Writer side of the FIR weight interface. Coefficients stream into a shadow
// bank over valid/ready, then the whole set is copied into the active bank on
// a sample boundary so the filter never sees a mix of old and new taps.
//
//   state | meaning
//   IDLE  | no load in progress, coef_valid ignored
//   LOAD  | accepting coefficients into the shadow bank
//   PEND  | full set loaded, waiting for swap_en to commit it
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   load_start                    begin a new load at index 0 (restarts any load)
//   coef_valid/coef_data/coef_ready coefficient handshake, index order 0..TAPS-1
//   swap_en                       sample boundary, commits a pending set
//   weights                       active bank (registered)
//   busy                          high in LOAD or PEND
//   load_done                     pulse, aligned with the first cycle of new weights
//   coef_idx                      next shadow index to be written
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int TAPS   = 401,
    parameter int COEF_W = fir_pkg::COEF_W,
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              coef_valid,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_ready,
    input  logic              swap_en,
    output logic [COEF_W-1:0] weights [TAPS],
    output logic              busy,
    output logic              load_done,
    output logic [IDX_W-1:0]  coef_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    coef_ld_state_t state_q, state_d;
    logic [COEF_W-1:0] shadow_q [TAPS];
    logic [COEF_W-1:0] zero_word;
    logic accept;
    logic swap;

    // A handshake coinciding with load_start is dropped; load_start also beats swap_en.
    assign accept    = coef_valid && coef_ready && !load_start;
    assign swap      = (state_q == PEND) && swap_en && !load_start;
    assign zero_word = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load_start) state_d = LOAD;
            LOAD: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (accept && coef_idx == LAST_IDX) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (swap_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coef_ready = 1'b0;
        busy       = 1'b0;
        case (state_q)
            LOAD: begin
                coef_ready = 1'b1;
                busy       = 1'b1;
            end
            PEND:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_idx  <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= swap;
            if (load_start) begin
                coef_idx <= '0;
            end else if (accept) begin
                coef_idx <= (coef_idx == LAST_IDX) ? '0 : coef_idx + 1'b1;
            end
        end
    end

    fir_coef_bank #(.TAPS(TAPS), .W(COEF_W), .IDX_W(IDX_W)) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_idx    (coef_idx),
        .wr_data   (coef_data),
        .copy_en   (1'b0),
        .copy_data (weights),
        .q         (shadow_q)
    );

    fir_coef_bank #(.TAPS(TAPS), .W(COEF_W), .IDX_W(IDX_W)) u_active (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   (zero_word),
        .copy_en   (swap),
        .copy_data (shadow_q),
        .q         (weights)
    );

endmodule
